conv2_ctrl: RTL and testbench

CONV2_CTRL -- requirements
Module: conv2_ctrl

---
 rtl/conv2_ctrl.sv | 130 +++++++++++++
 tb/tb_conv2_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/conv2_ctrl.sv
// Sequencer for the 5x5 conv2 layer: walks output pixels, input channels and kernel taps,
// issuing feature-map/weight read addresses and accumulator/write strobes.
module conv2_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    output logic [9:0] fmap_addr,
    output logic [7:0] w_addr,
    output logic       acc_en,
    output logic       acc_clr,
    output logic       out_wr,
    output logic [5:0] out_addr,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

    state_t     state;
    logic [5:0] p;
    logic [2:0] kx;
    logic [2:0] ky;
    logic [9:0] pix_base;
    logic [9:0] next_base;
    logic       acc_en_q;
    logic       acc_clr_q;
    logic       out_wr_q;
    logic       hold;

    // Top-left input pixel of the next output pixel: step one column, or wrap to the next row.
    assign next_base = pix_base + ((p[2:0] == 3'd7) ? 10'd5 : 10'd1);

    // Strobes are masked while frozen so a pending acc_en survives the stall and fires on release.
    assign hold     = stall & busy;
    assign acc_en   = acc_en_q & ~hold;
    assign acc_clr  = acc_clr_q & ~hold;
    assign out_wr   = out_wr_q & ~hold;
    assign out_addr = p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            p         <= '0;
            kx        <= '0;
            ky        <= '0;
            pix_base  <= '0;
            fmap_addr <= '0;
            w_addr    <= '0;
            acc_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            out_wr_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        acc_en_q  <= 1'b1;
                        acc_clr_q <= (w_addr == 8'd0);
                        if (w_addr == 8'd149) begin
                            state <= DRAIN;
                        end else begin
                            w_addr <= w_addr + 8'd1;
                            // Address steps: next tap in row, next kernel row, or next channel plane.
                            if (kx != 3'd4) begin
                                kx        <= kx + 3'd1;
                                fmap_addr <= fmap_addr + 10'd1;
                            end else if (ky != 3'd4) begin
                                kx        <= '0;
                                ky        <= ky + 3'd1;
                                fmap_addr <= fmap_addr + 10'd8;
                            end else begin
                                kx        <= '0;
                                ky        <= '0;
                                fmap_addr <= fmap_addr + 10'd92;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        acc_en_q  <= 1'b0;
                        acc_clr_q <= 1'b0;
                        out_wr_q  <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        out_wr_q <= 1'b0;
                        kx       <= '0;
                        ky       <= '0;
                        w_addr   <= '0;
                        if (p == 6'd63) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            p         <= p + 6'd1;
                            pix_base  <= next_base;
                            fmap_addr <= next_base;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    p         <= '0;
                    pix_base  <= '0;
                    fmap_addr <= '0;
                    w_addr    <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2_ctrl.sv
// Directed bench for conv2_ctrl: full passes checked cycle by cycle against a closed-form
// address model, with stalls, a mid-run reset and a start request while busy.
module tb_conv2_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stall;
    logic [9:0] fmap_addr;
    logic [7:0] w_addr;
    logic       acc_en;
    logic       acc_clr;
    logic       out_wr;
    logic [5:0] out_addr;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    conv2_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .fmap_addr(fmap_addr), .w_addr(w_addr), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_wr(out_wr), .out_addr(out_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // {done, busy, out_addr, out_wr, acc_clr, acc_en, w_addr, fmap_addr}
    function automatic logic [31:0] snap();
        return {3'b000, done, busy, out_addr, out_wr, acc_clr, acc_en, w_addr, fmap_addr};
    endfunction

    // Called at the falling edge inside the first RUN cycle. n counts non-stalled cycles.
    task automatic run_pass(input int sa, input int la, input int sb, input int lb,
                            input int abort_n, input int poke_n, input bit stall_done,
                            input bit directed);
        int n = 0;
        int held = 0;
        int total = 0;
        int done_at = -1;
        int pix, k, chn, t, r, c, f;
        logic [31:0] e, m;
        while (n <= 9729 && total < 12000) begin
            stall = ((n == sa && held < la) || (n == sb && held < lb) ||
                     (n == 9728 && stall_done)) ? 1'b1 : 1'b0;
            start = (n == poke_n) ? 1'b1 : 1'b0;
            if (n == abort_n) begin
                reset = 1'b1;
                stall = 1'b0;
                start = 1'b0;
                #1;
                chk("reset_midrun", snap(), 32'h0);
                return;
            end
            #1;
            if (done === 1'b1 && done_at < 0) done_at = total;
            pix = n / 152;
            k   = n % 152;
            e   = 32'h0;
            m   = 32'h1FFF_FFFF;
            if (n == 9728) begin
                e[28] = 1'b1;
                m = m & ~(32'h3F << 21) & ~32'h3FFFF;
            end else if (n == 9729) begin
                e = 32'h0;
            end else if (k < 150) begin
                chn = k / 25; t = k % 25; r = pix / 8; c = pix % 8;
                f = chn * 144 + (r + t / 5) * 12 + c + t % 5;
                e[9:0]   = f[9:0];
                e[17:10] = 8'(chn * 25 + t);
                e[18]    = (k > 0) && !stall;
                e[19]    = (k == 1) && !stall;
                e[27]    = 1'b1;
                m = m & ~(32'h3F << 21);
            end else if (k == 150) begin
                e[18] = !stall;
                e[27] = 1'b1;
                m = m & ~(32'h3F << 21) & ~32'h3FFFF;
            end else begin
                e[20]    = !stall;
                e[26:21] = 6'(pix);
                e[27]    = 1'b1;
                m = m & ~32'h3FFFF;
            end
            chk($sformatf("cyc%0d%s", n, stall ? "_stalled" : ""), snap() & m, e & m);
            if (directed) begin
                case (n)
                    0:    begin chk("start_busy", 32'(busy), 1); chk("start_fmap", 32'(fmap_addr), 0);
                                chk("start_w", 32'(w_addr), 0); end
                    1:    begin chk("first_acc_en", 32'(acc_en), 1); chk("first_acc_clr", 32'(acc_clr), 1); end
                    5:    begin chk("t5_fmap", 32'(fmap_addr), 12); chk("t5_w", 32'(w_addr), 5); end
                    25:   begin chk("ch1_fmap", 32'(fmap_addr), 144); chk("ch1_w", 32'(w_addr), 25); end
                    26:   begin chk("ch1_acc_en", 32'(acc_en), 1); chk("ch1_acc_clr", 32'(acc_clr), 0); end
                    1368: chk("p9_fmap", 32'(fmap_addr), 13);
                    1519: begin chk("p9_out_wr", 32'(out_wr), 1); chk("p9_out_addr", 32'(out_addr), 9); end
                    9725: begin chk("last_fmap", 32'(fmap_addr), 863); chk("last_w", 32'(w_addr), 149); end
                    9727: chk("last_out_addr", 32'(out_addr), 63);
                    9728: begin chk("done_pulse", 32'(done), 1); chk("done_busy", 32'(busy), 0); end
                    9729: chk("back_idle", 32'({busy, done}), 0);
                    default: ;
                endcase
            end
            if (stall && n < 9728) held++;
            else begin
                n++;
                held = 0;
            end
            total++;
            @(negedge clk);
        end
        stall = 1'b0;
        start = 1'b0;
        chk("cycles_to_done", 32'(done_at), 32'(9728 + la + lb));
    endtask

    task automatic launch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", snap(), 32'h0);
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold", snap(), 32'h0);

        // Stall is ignored in IDLE: launch with stall high.
        stall = 1'b1;
        launch();
        run_pass(-1, 0, -1, 0, -1, 50, 1'b0, 1'b1);

        // Stalls in WRITE (2 cycles) and mid-RUN (5 cycles), plus stall during DONE.
        launch();
        run_pass(151, 2, 1000, 5, -1, -1, 1'b1, 1'b0);

        // Reset at p=20 mid-RUN, then the interrupted pass must not resume.
        launch();
        run_pass(-1, 0, -1, 0, 20 * 152 + 10, 60, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_resume", snap(), 32'h0);
        end

        launch();
        run_pass(-1, 0, -1, 0, -1, 3000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
